// File: rtl/spi_serializer_param.sv
// Parametrised SPI master transmitter: four CPOL/CPHA modes, MSB/LSB order, SCLK divider, CS gap.
// Defining SPI_SERIALIZER_RX_EN adds the MISO input and the rx_data receive path.
module spi_serializer_param #(
    parameter int DATA_W    = 32,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int CS_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Data_Register,
    input  logic              ld,
`ifdef SPI_SERIALIZER_RX_EN
    input  logic              MISO,
    output logic [DATA_W-1:0] rx_data,
`endif
    output logic              ready,
    output logic              DataBit,
    output logic              SPI_clk,
    output logic              CS,
    output logic              done
);

    localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int ECW = $clog2(2 * DATA_W + 1);
    localparam int GCW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [HCW-1:0] HALF_LAST = HCW'(CLK_DIV - 1);
    localparam logic [ECW-1:0] EDGE_LAST = ECW'(2 * DATA_W - 1);
    localparam logic [GCW-1:0] GAP_LOAD  = GCW'(CS_GAP - 1);
    localparam logic [GCW-1:0] GAP_ONE   = GCW'(1);
    localparam logic           IDLE_CLK  = (CPOL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Bit that leaves the word first in the configured order.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        first_bit = (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // Word with the outgoing bit removed, so first_bit() yields the following one.
    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        shift_word = (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    state_t            state_q, state_d;
    logic [HCW-1:0]    half_q, half_d;
    logic [ECW-1:0]    edge_q, edge_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ready_q, ready_d;
    logic              dbit_q, dbit_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              done_q, done_d;

    logic              half_wrap_s;
    logic              leading_s;
    logic              drive_s;

    // edge_q counts SPI_clk edges already produced, so the upcoming edge is odd (leading) when it is even.
    assign half_wrap_s = (half_q == HALF_LAST);
    assign leading_s   = ~edge_q[0];
    assign drive_s     = (CPHA != 0) ? leading_s : (~leading_s & (edge_q != EDGE_LAST));

`ifdef SPI_SERIALIZER_RX_EN
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sample_s;

    // Receive word assembled in transmit order, so the first sampled bit lands on the first transmitted index.
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
        rx_shift = (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign sample_s = (CPHA != 0) ? ~leading_s : leading_s;
`endif

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        edge_d  = edge_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        dbit_d  = dbit_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
`ifdef SPI_SERIALIZER_RX_EN
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (ld && ready_q) begin
                    state_d = SHIFT;
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                    half_d  = '0;
                    edge_d  = '0;
                    if (CPHA == 0) begin
                        dbit_d  = first_bit(Data_Register);
                        shreg_d = shift_word(Data_Register);
                    end else begin
                        dbit_d  = 1'b0;
                        shreg_d = Data_Register;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (half_wrap_s) begin
                    half_d = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + ECW'(1);
                    if (drive_s) begin
                        dbit_d  = first_bit(shreg_q);
                        shreg_d = shift_word(shreg_q);
                    end else begin
                        dbit_d = dbit_q;
                    end
`ifdef SPI_SERIALIZER_RX_EN
                    if (sample_s) begin
                        rx_sh_d = rx_shift(rx_sh_q, MISO);
                    end else begin
                        rx_sh_d = rx_sh_q;
                    end
`endif
                    if (edge_q == EDGE_LAST) begin
                        state_d = HOLD;
                        sclk_d  = IDLE_CLK;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    half_d = half_q + HCW'(1);
                end
            end
            HOLD: begin
                if (half_wrap_s) begin
                    half_d = '0;
                    cs_d   = 1'b1;
                    dbit_d = 1'b0;
                    done_d = 1'b1;
`ifdef SPI_SERIALIZER_RX_EN
                    rx_data_d = rx_sh_q;
`endif
                    // A one-cycle gap is satisfied by the done cycle itself.
                    if (CS_GAP == 1) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        gap_d   = '0;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end else begin
                    half_d = half_q + HCW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_ONE) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                half_d  = '0;
                edge_d  = '0;
                gap_d   = '0;
                ready_d = 1'b1;
                dbit_d  = 1'b0;
                sclk_d  = IDLE_CLK;
                cs_d    = 1'b1;
            end
        endcase
    end

    // Sequencer state, counters and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            half_q  <= '0;
            edge_q  <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b1;
            dbit_q  <= 1'b0;
            sclk_q  <= IDLE_CLK;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            edge_q  <= edge_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            dbit_q  <= dbit_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_SERIALIZER_RX_EN
    // Receive shift register and the word published at end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`endif

    assign ready   = ready_q;
    assign DataBit = dbit_q;
    assign SPI_clk = sclk_q;
    assign CS      = cs_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_serializer_param.sv
// Scoreboard bench for spi_serializer_param over several parameter sets (all four modes, both orders,
// CLK_DIV/CS_GAP boundaries); with SPI_SERIALIZER_RX_EN the MISO line is looped back from DataBit.
module tb_spi_serializer_param;

    localparam int NCFG = 5;

    logic clk;
    int   n_pass  = 0;
    int   n_total = 0;
    int   fin_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input int cfg, input string name, input bit ok,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, name, act, exp);
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W      = (g == 3) ? 32 : ((g == 4) ? 2 : 8);
        localparam int DIV    = (g == 3) ? 3 : ((g == 4) ? 1 : 2);
        localparam int CPOL_P = (g == 2 || g == 4) ? 1 : 0;
        localparam int CPHA_P = (g == 2 || g == 3) ? 1 : 0;
        localparam int MSB_P  = (g == 1 || g == 3) ? 0 : 1;
        localparam int GAP_P  = (g == 3) ? 3 : ((g == 4) ? 1 : 2);
        localparam logic [31:0] DIR = (g == 0) ? 32'hA5 : (g == 1) ? 32'h1E : (g == 2) ? 32'h3C :
                                      (g == 3) ? 32'h8D6C9E01 : 32'h2;
        localparam int RST_EDGE = (2 * W > 5) ? 5 : 3;
        localparam logic IDLE_LVL = (CPOL_P != 0) ? 1'b1 : 1'b0;
        localparam logic SAMP_LVL = (CPHA_P != 0) ? IDLE_LVL : ~IDLE_LVL;

        logic         rst_n;
        logic         ld;
        logic [W-1:0] data;
        logic         ready, dbit, sclk, cs, done_o;
`ifdef SPI_SERIALIZER_RX_EN
        logic         miso;
        logic [W-1:0] rx_data;
        assign miso = dbit;
`endif

        logic [W-1:0] exp_q[$];
        int           lowc = 0, nedge = 0, nbits = 0, highc = 0, last_gap = 0, done_seen = 0;
        bit           bad = 1'b0;
        logic [W-1:0] cap = '0;

        spi_serializer_param #(
            .DATA_W(W), .CLK_DIV(DIV), .CPOL(CPOL_P), .CPHA(CPHA_P),
            .MSB_FIRST(MSB_P), .CS_GAP(GAP_P)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .Data_Register(data),
            .ld           (ld),
`ifdef SPI_SERIALIZER_RX_EN
            .MISO         (miso),
            .rx_data      (rx_data),
`endif
            .ready        (ready),
            .DataBit      (dbit),
            .SPI_clk      (sclk),
            .CS           (cs),
            .done         (done_o)
        );

        task automatic check_reset_outputs(input string tag);
            check(g, {tag, "_cs"},    cs === 1'b1,       64'(cs),     64'd1);
            check(g, {tag, "_sclk"},  sclk === IDLE_LVL, 64'(sclk),   64'(IDLE_LVL));
            check(g, {tag, "_dbit"},  dbit === 1'b0,     64'(dbit),   64'd0);
            check(g, {tag, "_ready"}, ready === 1'b1,    64'(ready),  64'd1);
            check(g, {tag, "_done"},  done_o === 1'b0,   64'(done_o), 64'd0);
`ifdef SPI_SERIALIZER_RX_EN
            check(g, {tag, "_rx"},    rx_data === '0,    64'(rx_data), 64'd0);
`endif
        endtask

        task automatic send(input logic [W-1:0] d);
            int t;
            t = 0;
            @(negedge clk);
            while (ready !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (ready !== 1'b1) begin
                check(g, "ready_timeout", 1'b0, 64'(ready), 64'd1);
            end else begin
                data = d;
                ld   = 1'b1;
                exp_q.push_back(d);
                @(negedge clk);
                ld   = 1'b0;
                data = W'($urandom);
                check(g, "accept_busy", ready === 1'b0 && cs === 1'b0, 64'({ready, cs}), 64'd0);
            end
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            while ((exp_q.size() != 0 || ready !== 1'b1) && t < 5000) begin
                @(negedge clk);
                t++;
            end
            check(g, "frame_complete", exp_q.size() == 0 && ready === 1'b1,
                  64'(exp_q.size()), 64'd0);
        endtask

        // Monitor: reconstructs each frame from the pins and scores it when done pulses.
        initial begin : mon
            logic         pcs, psclk, pdb, pdone;
            logic [W-1:0] exp;
            int           idx;
            pcs = 1'b1; psclk = IDLE_LVL; pdb = 1'b0; pdone = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    lowc = 0; nedge = 0; nbits = 0; bad = 1'b0; cap = '0;
                end else begin
                    if (cs === 1'b0) begin
                        if (pcs === 1'b1) begin
                            last_gap = highc;
                            highc = 0;
                        end
                        lowc++;
                        if (sclk !== psclk) begin
                            nedge++;
                            if (sclk === SAMP_LVL && nbits < W) begin
                                idx = (MSB_P != 0) ? (W - 1 - nbits) : nbits;
                                cap[idx] = dbit;
                                nbits++;
                            end
                        end
                        if (dbit !== pdb && pcs !== 1'b1 && !(sclk !== psclk && sclk !== SAMP_LVL))
                            bad = 1'b1;
                    end else begin
                        highc++;
                        if (sclk !== IDLE_LVL || dbit !== 1'b0) bad = 1'b1;
                    end
                    if (done_o === 1'b1) begin
                        done_seen++;
                        check(g, "done_single", pdone !== 1'b1, 64'(pdone), 64'd0);
                        if (exp_q.size() == 0) begin
                            check(g, "done_unexpected", 1'b0, 64'd1, 64'd0);
                        end else begin
                            exp = exp_q.pop_front();
                            check(g, "tx_word", cap === exp, 64'(cap), 64'(exp));
                            check(g, "cs_low_len", lowc == (2 * W + 1) * DIV, 64'(lowc),
                                  64'((2 * W + 1) * DIV));
                            check(g, "sclk_edges", nedge == 2 * W, 64'(nedge), 64'(2 * W));
                            check(g, "done_at_cs_rise", cs === 1'b1 && pcs === 1'b0,
                                  64'({cs, pcs}), 64'h2);
                            check(g, "dbit_timing", bad == 1'b0, 64'(bad), 64'd0);
`ifdef SPI_SERIALIZER_RX_EN
                            check(g, "rx_word", rx_data === exp, 64'(rx_data), 64'(exp));
`endif
                        end
                        lowc = 0; nedge = 0; nbits = 0; bad = 1'b0; cap = '0;
                    end
                end
                pcs = cs; psclk = sclk; pdb = dbit; pdone = done_o;
            end
        end

        initial begin : drv
            int   t, e, d0;
            logic ps;
            rst_n = 1'b0;
            ld    = 1'b0;
            data  = '0;
            repeat (3) @(negedge clk);
            check_reset_outputs("reset_idle");
            rst_n = 1'b1;

            send(W'(DIR));
            wait_idle();
            for (int i = 0; i < 4; i++) begin
                send(W'($urandom));
                if ($urandom_range(0, 1) == 1) wait_idle();
            end
            wait_idle();

            // Back-to-back frames with ld held high, then stray ld pulses while busy.
            d0 = done_seen;
            @(negedge clk);
            data = W'(32'hA5);
            ld   = 1'b1;
            exp_q.push_back(W'(32'hA5));
            @(negedge clk);
            data = W'(32'h5A);
            exp_q.push_back(W'(32'h5A));
            t = 0;
            while (ready !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            ld = 1'b0;
            #1;
            check(g, "b2b_second_accept", cs === 1'b0 && ready === 1'b0, 64'({cs, ready}), 64'd0);
            check(g, "b2b_gap", last_gap == GAP_P, 64'(last_gap), 64'(GAP_P));
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (ready === 1'b0) ld = 1'b1;
                @(negedge clk);
                ld = 1'b0;
            end
            wait_idle();
            repeat ((2 * W + 1) * DIV + 8) @(negedge clk);
            check(g, "no_third_frame", cs === 1'b1 && done_seen == d0 + 2, 64'(done_seen - d0), 64'd2);

            // Reset in the middle of a frame.
            d0 = done_seen;
            send(W'($urandom));
            e  = 0;
            t  = 0;
            ps = sclk;
            while (e < RST_EDGE && t < 1000) begin
                @(negedge clk);
                if (sclk !== ps) e++;
                ps = sclk;
                t++;
            end
            check(g, "reset_edge_reached", e == RST_EDGE, 64'(e), 64'(RST_EDGE));
            rst_n = 1'b0;
            #1;
            check_reset_outputs("reset_midframe");
            exp_q.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat ((2 * W + 1) * DIV + 8) @(negedge clk);
            check(g, "no_done_after_reset", done_seen == d0, 64'(done_seen - d0), 64'd0);
            fin_cnt++;
        end
    end

    initial begin : summary
        int t;
        t = 0;
        while (fin_cnt < NCFG && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (fin_cnt < NCFG) check(-1, "global_timeout", 1'b0, 64'(fin_cnt), 64'(NCFG));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
